// File: rtl/f2i_job_ctrl.sv
// f2i_job_ctrl: sequences float-to-int jobs on the tinyarch core (write float, pulse req, wait ack, read result).
// Latency: 2 + REQ_CYCLES + (k+1) + 3 cycles from accept to out_valid (k = ack delay in WAIT); TIMEOUT bounds the wait.
// Backpressure: one job in flight; in_ready only in IDLE; result held in DONE until out_valid && out_ready.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   in_valid/in_ready   host float stream, in_flt = {sign, exp[4:0], frac[9:0]}
//   dm_wr_en/dm_addr/dm_wdata/dm_rdata  core data-memory port (read data one cycle after address)
//   req/ack             core start pulse / done level
//   out_valid/out_ready result stream, out_int big-endian result word, out_err = job timed out
//   busy                high whenever a job is in progress
module f2i_job_ctrl #(
    parameter int REQ_CYCLES = 1,
    parameter int TIMEOUT    = 4096,
    parameter int ADDR_W     = 8,
    parameter int IN_ADDR    = 4,
    parameter int OUT_ADDR   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_flt,
    output logic              dm_wr_en,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [7:0]        dm_wdata,
    input  logic [7:0]        dm_rdata,
    output logic              req,
    input  logic              ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_int,
    output logic              out_err,
    output logic              busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        WR_HI,
        WR_LO,
        REQ,
        WAIT,
        RD_HI,
        RD_LO,
        CAP,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        flt_q;
    logic [3:0]         req_cnt_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        out_int_q;
    logic               out_err_q;
    logic               timeout_hit;

    // Last wait cycle with no ack: this is where the job gives up.
    assign timeout_hit = (state_q == WAIT) && !ack && (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        dm_wr_en  = 1'b0;
        dm_addr   = addr_q;     // address bus holds its last driven value
        dm_wdata  = 8'h00;
        req       = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = WR_HI;
            end
            WR_HI: begin
                dm_wr_en = 1'b1;
                dm_addr  = ADDR_W'(IN_ADDR);
                dm_wdata = flt_q[15:8];
                state_d  = WR_LO;
            end
            WR_LO: begin
                dm_wr_en = 1'b1;
                dm_addr  = ADDR_W'(IN_ADDR + 1);
                dm_wdata = flt_q[7:0];
                state_d  = REQ;
            end
            REQ: begin
                // ack is deliberately not looked at here: a level left over
                // from the previous job must not complete this one.
                req = 1'b1;
                if (req_cnt_q == 4'(REQ_CYCLES - 1)) state_d = WAIT;
            end
            WAIT: begin
                if (ack)              state_d = RD_HI;
                else if (timeout_hit) state_d = DONE;
            end
            RD_HI: begin
                dm_addr = ADDR_W'(OUT_ADDR);
                state_d = RD_LO;
            end
            RD_LO: begin
                dm_addr = ADDR_W'(OUT_ADDR + 1);
                state_d = CAP;
            end
            CAP: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            flt_q      <= 16'h0000;
            req_cnt_q  <= 4'd0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            out_int_q  <= 16'h0000;
            out_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= dm_addr;

            if (state_q == IDLE && in_valid) flt_q <= in_flt;

            req_cnt_q  <= (state_q == REQ)  ? req_cnt_q + 4'd1 : 4'd0;
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + WAIT_W'(1) : '0;

            // Read data trails the address by one cycle: the high byte
            // addressed in RD_HI arrives in RD_LO, the low byte in CAP.
            if (state_q == RD_LO) out_int_q[15:8] <= dm_rdata;
            if (state_q == CAP) begin
                out_int_q[7:0] <= dm_rdata;
                out_err_q      <= 1'b0;
            end
            if (timeout_hit) begin
                out_int_q <= 16'h8000;
                out_err_q <= 1'b1;
            end
        end
    end

    assign out_int = out_int_q;
    assign out_err = out_err_q;

endmodule
